servo_pwm_multi: RTL and testbench

Parametrised multi-channel hobby-servo PWM generator; successor to the single-channel fixed-duty servo driver. It generates `NUM_CH` PWM outputs from one shared frame counter. Each channel has a programmable pulse width, clamped to a safe servo range, with an optional per-frame slew limit. Pulse width and enable changes take effect only at frame boundaries, so no runt or glitched pulses reach the forklift actuators.

---
 rtl/servo_pkg.sv | 33 +++
 rtl/servo_pwm_multi_if.sv | 20 ++
 rtl/servo_slew_ch.sv | 85 ++++++++
 rtl/servo_pwm_multi.sv | 79 +++++++
 tb/tb_servo_pwm_multi.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared helpers for the multi-channel servo PWM generator.
//   cw_of(period)  - counter/width bit count, clog2(period+1)
//   chw_of(nch)    - channel index bit count, clog2(nch), at least 1
//   center(lo, hi) - power-on pulse width, midpoint of the legal range
//   clamp(w,lo,hi) - force a requested width into [lo, hi]
package servo_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int cw_of(input int period);
        return clog2(period + 1);
    endfunction

    function automatic int chw_of(input int nch);
        return (clog2(nch) < 1) ? 1 : clog2(nch);
    endfunction

    function automatic int center(input int lo, input int hi);
        return (lo + hi) / 2;
    endfunction

    function automatic int clamp(input int w, input int lo, input int hi);
        if (w < lo) return lo;
        if (w > hi) return hi;
        return w;
    endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// servo_pwm_multi_if: width-write port of servo_pwm_multi.
//   wr_valid/wr_ready - request handshake (accepted when both high)
//   wr_ch             - target channel
//   wr_width          - requested pulse width in clocks
//   wr_en             - channel enable written with the width
//   wr_err            - one-cycle pulse: accepted write hit a nonexistent channel
interface servo_pwm_multi_if #(
    parameter int CHW = 2,
    parameter int CW  = 20
);
    logic           wr_valid;
    logic           wr_ready;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_width;
    logic           wr_en;
    logic           wr_err;

    modport master (output wr_valid, wr_ch, wr_width, wr_en, input wr_ready, wr_err);
    modport slave  (input wr_valid, wr_ch, wr_width, wr_en, output wr_ready, wr_err);
endinterface

// File: rtl/servo_slew_ch.sv
// servo_slew_ch: one servo channel.
//   Holds the write target (tgt) and the applied value (act). A write strobe
//   updates the clamped target; on load_i (last cycle of the frame) the applied
//   value steps toward the target by at most SLEW_CYC (0 = jump).
//   clock_clk, reset_low - clock, async active-low reset
//   load_i               - frame load cycle
//   cnt_i                - shared frame counter
//   wr_stb_i             - write to this channel accepted this cycle
//   wr_width_i, wr_en_i  - write payload
//   pwm_o                - registered PWM output
module servo_slew_ch
    import servo_pkg::*;
#(
    parameter int CW       = 20,
    parameter int MIN_CYC  = 50000,
    parameter int MAX_CYC  = 100000,
    parameter int SLEW_CYC = 0
) (
    input  logic          clock_clk,
    input  logic          reset_low,
    input  logic          load_i,
    input  logic [CW-1:0] cnt_i,
    input  logic          wr_stb_i,
    input  logic [CW-1:0] wr_width_i,
    input  logic          wr_en_i,
    output logic          pwm_o
);
    localparam logic [CW-1:0] CENTER_W = CW'(center(MIN_CYC, MAX_CYC));
    localparam logic [CW:0]   SLEW_X   = (CW+1)'(SLEW_CYC);
    localparam logic [CW-1:0] SLEW_N   = CW'(SLEW_CYC);

    logic [CW-1:0] tgt_w_q, tgt_w_d, act_w_q, act_w_d;
    logic          tgt_en_q, tgt_en_d, act_en_q, act_en_d;
    logic          pwm_q, pwm_d;
    logic [CW:0]   up_diff, dn_diff;
    logic          tgt_ge, in_reach;

    always_comb begin
        tgt_w_d  = tgt_w_q;
        tgt_en_d = tgt_en_q;
        if (wr_stb_i) begin
            tgt_w_d  = CW'(clamp(int'(32'(wr_width_i)), MIN_CYC, MAX_CYC));
            tgt_en_d = wr_en_i;
        end
    end

    // Differences are taken one bit wider so the unused direction can never
    // wrap into a small value and falsely look "within reach".
    always_comb begin
        up_diff  = {1'b0, tgt_w_q} - {1'b0, act_w_q};
        dn_diff  = {1'b0, act_w_q} - {1'b0, tgt_w_q};
        tgt_ge   = (tgt_w_q >= act_w_q);
        in_reach = tgt_ge ? (up_diff <= SLEW_X) : (dn_diff <= SLEW_X);
        act_w_d  = act_w_q;
        act_en_d = act_en_q;
        if (load_i) begin
            act_en_d = tgt_en_q;
            if (SLEW_CYC == 0 || in_reach) act_w_d = tgt_w_q;
            else if (tgt_ge)               act_w_d = act_w_q + SLEW_N;
            else                           act_w_d = act_w_q - SLEW_N;
        end
    end

    // Uses pre-load act values; at the load cycle cnt is PERIOD-1, which is
    // beyond any legal width, so the output is low either way.
    assign pwm_d = act_en_q && (cnt_i < act_w_q);

    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            tgt_w_q  <= CENTER_W;
            act_w_q  <= CENTER_W;
            tgt_en_q <= 1'b0;
            act_en_q <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            tgt_w_q  <= tgt_w_d;
            act_w_q  <= act_w_d;
            tgt_en_q <= tgt_en_d;
            act_en_q <= act_en_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: NUM_CH hobby-servo PWM outputs from one frame counter.
//   clock_clk, reset_low - clock, async active-low reset
//   wr                   - write port (servo_pwm_multi_if.slave)
//   frame_start          - one-cycle pulse with the first pulse cycle of a frame
//   pwm_out              - per-channel PWM, registered
// Widths and enables only change in the load cycle (cnt == PERIOD_CYC-1),
// during which writes are stalled so a write never races the load.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int PERIOD_CYC = 1000000,
    parameter int MIN_CYC    = 50000,
    parameter int MAX_CYC    = 100000,
    parameter int SLEW_CYC   = 0
) (
    input  logic              clock_clk,
    input  logic              reset_low,
    servo_pwm_multi_if.slave  wr,
    output logic              frame_start,
    output logic [NUM_CH-1:0] pwm_out
);
    localparam int CW  = cw_of(PERIOD_CYC);
    localparam int CHW = chw_of(NUM_CH);
    localparam logic [CW-1:0] LAST  = CW'(PERIOD_CYC - 1);
    localparam logic [CHW:0]  NCH_X = (CHW+1)'(NUM_CH);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ready_q, ld_q, fs_q, err_q;
    logic              load, accept, ch_ok;
    logic [NUM_CH-1:0] wr_stb;

    assign load   = (cnt_q == LAST);
    assign cnt_d  = load ? '0 : cnt_q + 1'b1;
    assign accept = wr.wr_valid && ready_q;
    assign ch_ok  = ({1'b0, wr.wr_ch} < NCH_X);

    // ld_q marks cnt==0 after a real wrap, so frame_start is suppressed in
    // the first frame after reset (nothing was loaded yet).
    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            cnt_q   <= '0;
            ready_q <= 1'b1;
            ld_q    <= 1'b0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != LAST);
            ld_q    <= load;
            fs_q    <= ld_q;
            err_q   <= accept && !ch_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_stb[i] = accept && ch_ok && (wr.wr_ch == CHW'(i));

        servo_slew_ch #(
            .CW       (CW),
            .MIN_CYC  (MIN_CYC),
            .MAX_CYC  (MAX_CYC),
            .SLEW_CYC (SLEW_CYC)
        ) u_ch (
            .clock_clk  (clock_clk),
            .reset_low  (reset_low),
            .load_i     (load),
            .cnt_i      (cnt_q),
            .wr_stb_i   (wr_stb[i]),
            .wr_width_i (wr.wr_width),
            .wr_en_i    (wr.wr_en),
            .pwm_o      (pwm_out[i])
        );
    end

    assign wr.wr_ready = ready_q;
    assign wr.wr_err   = err_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: DUT A (4 channels) is shadowed every cycle by a
// frame-level reference model; DUT B (3 channels) covers the bad-channel
// error pulse and mid-frame reset.
module tb_servo_pwm_multi;
    import servo_pkg::*;

    localparam int P  = 100;
    localparam int MN = 10;
    localparam int MX = 20;
    localparam int S  = 2;
    localparam int CWT = cw_of(P);

    logic clk = 1'b0;
    logic rst_a = 1'b0, rst_b = 1'b0;
    logic fs_a, fs_b;
    logic [3:0] pwm_a;
    logic [2:0] pwm_b;

    always #5 clk = ~clk;

    servo_pwm_multi_if #(.CHW(2), .CW(CWT)) ifa ();
    servo_pwm_multi_if #(.CHW(2), .CW(CWT)) ifb ();

    servo_pwm_multi #(.NUM_CH(4), .PERIOD_CYC(P), .MIN_CYC(MN), .MAX_CYC(MX), .SLEW_CYC(S)) dut_a (
        .clock_clk(clk), .reset_low(rst_a), .wr(ifa), .frame_start(fs_a), .pwm_out(pwm_a));
    servo_pwm_multi #(.NUM_CH(3), .PERIOD_CYC(P), .MIN_CYC(MN), .MAX_CYC(MX), .SLEW_CYC(S)) dut_b (
        .clock_clk(clk), .reset_low(rst_b), .wr(ifb), .frame_start(fs_b), .pwm_out(pwm_b));

    int n_chk = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model of DUT A: frame position, targets and applied widths.
    int cur_a = 0, cur_b = 0;
    bit wrapped = 0;
    int tgt_w[4], act_w[4];
    bit tgt_en[4], act_en[4];

    function automatic int clampi(input int w);
        return (w < MN) ? MN : (w > MX) ? MX : w;
    endfunction

    task automatic step();
        int e_pwm, e_fs, e_rdy, d;
        @(posedge clk);
        e_pwm = 0; e_fs = 0;
        if (!rst_a) begin
            cur_a = 0; wrapped = 0;
            for (int i = 0; i < 4; i++) begin
                tgt_w[i] = (MN + MX) / 2; act_w[i] = (MN + MX) / 2;
                tgt_en[i] = 0; act_en[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++)
                if (act_en[i] && cur_a < act_w[i]) e_pwm |= (1 << i);
            e_fs = (cur_a == 0 && wrapped) ? 1 : 0;
            if (ifa.wr_valid && cur_a != P - 1) begin
                tgt_w[int'(ifa.wr_ch)]  = clampi(int'(ifa.wr_width));
                tgt_en[int'(ifa.wr_ch)] = ifa.wr_en;
            end
            if (cur_a == P - 1) begin
                for (int i = 0; i < 4; i++) begin
                    act_en[i] = tgt_en[i];
                    d = tgt_w[i] - act_w[i];
                    if (d > S)       act_w[i] += S;
                    else if (d < -S) act_w[i] -= S;
                    else             act_w[i] = tgt_w[i];
                end
                wrapped = 1;
            end
            cur_a = (cur_a + 1) % P;
        end
        e_rdy = (cur_a != P - 1) ? 1 : 0;
        cur_b = rst_b ? (cur_b + 1) % P : 0;
        #1;
        chk("pwm_a", int'(pwm_a), e_pwm);
        chk("fs_a", int'(fs_a), e_fs);
        chk("rdy_a", int'(ifa.wr_ready), e_rdy);
        chk("err_a", int'(ifa.wr_err), 0);
    endtask

    task automatic to_a(input int c);
        while (cur_a != c) step();
    endtask

    task automatic to_b(input int c);
        while (cur_b != c) step();
    endtask

    task automatic wr_a(input int ch, input int wd, input int en);
        ifa.wr_valid = 1; ifa.wr_ch = 2'(ch); ifa.wr_width = CWT'(wd); ifa.wr_en = en[0];
        step();
        ifa.wr_valid = 0;
    endtask

    task automatic wr_b(input int ch, input int wd, input int en);
        ifb.wr_valid = 1; ifb.wr_ch = 2'(ch); ifb.wr_width = CWT'(wd); ifb.wr_en = en[0];
        step();
        ifb.wr_valid = 0;
    endtask

    // Count high cycles per channel over one frame window of DUT A, with an
    // optional single write issued at frame position 'at'.
    task automatic meas_a(output int w[4], input bit do_wr, input int at,
                          input int ch, input int wd, input int en);
        while (cur_a != 1) step();
        for (int i = 0; i < 4; i++) w[i] = 0;
        repeat (P) begin
            for (int i = 0; i < 4; i++) if (pwm_a[i]) w[i]++;
            if (do_wr && cur_a == at) wr_a(ch, wd, en);
            else step();
        end
    endtask

    task automatic meas_b(output int w[3]);
        while (cur_b != 1) step();
        for (int i = 0; i < 3; i++) w[i] = 0;
        repeat (P) begin
            for (int i = 0; i < 3; i++) if (pwm_b[i]) w[i]++;
            step();
        end
    endtask

    typedef struct {
        int ch;
        int wd;
        int en;
        int exp;
    } vec_t;

    vec_t tbl[8];
    int w[4];
    int wb[3];
    int cnt_fs, cnt_pw;
    int e0[3], e2[3];

    initial begin
        tbl[0] = '{0, 0, 1, 10};
        tbl[1] = '{0, 127, 1, 20};
        tbl[2] = '{1, 15, 1, 15};
        tbl[3] = '{2, 9, 1, 10};
        tbl[4] = '{3, 12, 1, 12};
        tbl[5] = '{3, 21, 0, 0};
        tbl[6] = '{1, 19, 1, 19};
        tbl[7] = '{2, 14, 1, 14};
        e0 = '{13, 11, 10};
        e2 = '{17, 19, 20};

        ifa.wr_valid = 0; ifa.wr_ch = '0; ifa.wr_width = '0; ifa.wr_en = 0;
        ifb.wr_valid = 0; ifb.wr_ch = '0; ifb.wr_width = '0; ifb.wr_en = 0;

        // Reset state
        repeat (3) step();
        chk("rst_pwm_a", int'(pwm_a), 0);
        chk("rst_fs_a", int'(fs_a), 0);
        chk("rst_err_b", int'(ifb.wr_err), 0);
        chk("rst_pwm_b", int'(pwm_b), 0);
        rst_a = 1; rst_b = 1;

        // Idle: frame_start every P cycles, outputs low
        cnt_fs = 0; cnt_pw = 0;
        for (int k = 0; k < 302; k++) begin
            step();
            if (fs_a) cnt_fs++;
            if (pwm_a != 0) cnt_pw++;
        end
        chk("idle_fs_count", cnt_fs, 3);
        chk("idle_pwm", cnt_pw, 0);

        // Single channel enable
        to_a(30); wr_a(1, 14, 1);
        meas_a(w, 0, 0, 0, 0, 0);
        chk("ch1_w", w[1], 14);
        chk("ch0_off", w[0], 0);
        chk("ch2_off", w[2], 0);
        chk("ch3_off", w[3], 0);

        // Clamp plus slew toward both ends
        to_a(30); wr_a(0, 5, 1); wr_a(2, 90, 1);
        for (int f = 0; f < 3; f++) begin
            meas_a(w, 0, 0, 0, 0, 0);
            chk($sformatf("slew_ch0_f%0d", f), w[0], e0[f]);
            chk($sformatf("slew_ch2_f%0d", f), w[2], e2[f]);
        end

        // Write presented in the load cycle stalls one cycle
        to_a(P - 1);
        ifa.wr_valid = 1; ifa.wr_ch = 2'd3; ifa.wr_width = CWT'(15); ifa.wr_en = 1;
        chk("stall_rdy", int'(ifa.wr_ready), 0);
        step();
        chk("accept_rdy", int'(ifa.wr_ready), 1);
        step();
        ifa.wr_valid = 0;
        meas_a(w, 0, 0, 0, 0, 0);
        chk("stall_f1_ch3", w[3], 0);
        meas_a(w, 0, 0, 0, 0, 0);
        chk("stall_f2_ch3", w[3], 15);

        // Disable mid-pulse: pulse completes, next frame low
        meas_a(w, 1, 5, 3, 15, 0);
        chk("dis_cur_ch3", w[3], 15);
        meas_a(w, 0, 0, 0, 0, 0);
        chk("dis_next_ch3", w[3], 0);

        // Table: settled width after several frames
        for (int t = 0; t < 8; t++) begin
            to_a(30);
            wr_a(tbl[t].ch, tbl[t].wd, tbl[t].en);
            repeat (6 * P) step();
            meas_a(w, 0, 0, 0, 0, 0);
            chk($sformatf("tbl%0d_ch%0d", t, tbl[t].ch), w[tbl[t].ch], tbl[t].exp);
        end

        // Random writes, checked each cycle by the model
        repeat (1500) begin
            ifa.wr_valid = ($urandom_range(0, 7) == 0);
            ifa.wr_ch    = 2'($urandom_range(0, 3));
            ifa.wr_width = CWT'($urandom_range(0, 127));
            ifa.wr_en    = 1'($urandom_range(0, 1));
            step();
        end
        ifa.wr_valid = 0;

        // DUT B: out-of-range channel and mid-frame reset
        to_b(30); wr_b(0, 12, 1);
        repeat (3 * P) step();
        meas_b(wb);
        chk("b_ch0", wb[0], 12);
        chk("b_ch1", wb[1], 0);
        to_b(20);
        ifb.wr_valid = 1; ifb.wr_ch = 2'd3; ifb.wr_width = CWT'(18); ifb.wr_en = 1;
        step();
        ifb.wr_valid = 0;
        chk("b_err_pulse", int'(ifb.wr_err), 1);
        step();
        chk("b_err_clr", int'(ifb.wr_err), 0);
        meas_b(wb);
        chk("b_keep_ch0", wb[0], 12);
        chk("b_keep_ch1", wb[1], 0);
        chk("b_keep_ch2", wb[2], 0);
        // Reset while ch0 is high so the asynchronous clear is visible
        to_b(5);
        chk("b_pre_rst", int'(pwm_b), 1);
        rst_b = 0;
        #1;
        chk("b_rst_pwm", int'(pwm_b), 0);
        chk("b_rst_fs", int'(fs_b), 0);
        chk("b_rst_err", int'(ifb.wr_err), 0);
        step();
        rst_b = 1;
        // Applied width restarts from centre 15: 15 -> 17 -> 19
        to_b(30); wr_b(0, 20, 1);
        meas_b(wb);
        chk("b_post_f1", wb[0], 17);
        meas_b(wb);
        chk("b_post_f2", wb[0], 19);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
